// File: rtl/alu_word_sequencer.sv
// Multi-word ADD/SUB/AND/XOR sequencer: slices 16*WORDS-bit operands into
// 16-bit words and issues them LSW-first to a shared combinational 16-bit ALU.
module alu_word_sequencer #(
  parameter int unsigned WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_op,
  input  logic [16*WORDS-1:0]  req_a,
  input  logic [16*WORDS-1:0]  req_b,
  input  logic                 req_ci,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [16*WORDS-1:0]  rsp_result,
  output logic                 rsp_co,
  output logic                 rsp_zero,
  output logic [15:0]          alu_a,
  output logic [15:0]          alu_b,
  output logic [4:0]           alu_operation,
  output logic                 alu_cin,
  input  logic [15:0]          alu_result,
  input  logic                 alu_cout
);

  localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_XOR = 2'b11
  } op_e;

  state_e               state;
  op_e                  op_q;
  logic [16*WORDS-1:0]  a_q;
  logic [16*WORDS-1:0]  b_q;
  logic                 ci_q;
  logic [IDX_W-1:0]     idx;
  logic                 carry_q;
  logic [16*WORDS-1:0]  result_q;
  logic                 co_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      op_q      <= OP_ADD;
      a_q       <= '0;
      b_q       <= '0;
      ci_q      <= 1'b0;
      idx       <= '0;
      carry_q   <= 1'b1;
      result_q  <= '0;
      co_q      <= 1'b0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_q      <= op_e'(req_op);
            a_q       <= req_a;
            b_q       <= req_b;
            ci_q      <= req_ci;
            idx       <= '0;
            req_ready <= 1'b0;
            state     <= S_EXEC;
          end
        end
        S_EXEC: begin
          for (int unsigned w = 0; w < WORDS; w++) begin
            if (idx == IDX_W'(w)) begin
              result_q[16*w +: 16] <= alu_result;
            end
          end
          carry_q <= alu_cout;
          idx     <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            // ALU carry pin is active-low: ADD carry is its inverse, SUB borrow is the pin itself
            case (op_q)
              OP_ADD:  co_q <= ~alu_cout;
              OP_SUB:  co_q <= alu_cout;
              default: co_q <= 1'b0;
            endcase
            rsp_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    alu_a         = '0;
    alu_b         = '0;
    alu_operation = '0;
    alu_cin       = 1'b1;
    if (state == S_EXEC) begin
      for (int unsigned w = 0; w < WORDS; w++) begin
        if (idx == IDX_W'(w)) begin
          alu_a = a_q[16*w +: 16];
          alu_b = b_q[16*w +: 16];
        end
      end
      case (op_q)
        OP_ADD:  alu_operation = 5'b01001;
        OP_SUB:  alu_operation = 5'b00110;
        OP_AND:  alu_operation = 5'b11011;
        default: alu_operation = 5'b10110;
      endcase
      // First slice injects the request carry; a low pin means +1 for both ADD and SUB
      if (idx == '0) begin
        case (op_q)
          OP_ADD:  alu_cin = ~ci_q;
          OP_SUB:  alu_cin = ci_q;
          default: alu_cin = 1'b1;
        endcase
      end else begin
        alu_cin = carry_q;
      end
    end
  end

  assign rsp_result = result_q;
  assign rsp_co     = co_q;
  assign rsp_zero   = (result_q == '0);

endmodule

// File: tb/tb_alu_word_sequencer.sv
// Self-checking bench for alu_word_sequencer: supplies a behavioural 16-bit ALU
// and checks full-width results against plain wide arithmetic.
module tb_alu_word_sequencer;

  localparam int unsigned WORDS = 4;
  localparam int unsigned W     = 16 * WORDS;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_op;
  logic [W-1:0]  req_a;
  logic [W-1:0]  req_b;
  logic          req_ci;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [W-1:0]  rsp_result;
  logic          rsp_co;
  logic          rsp_zero;
  logic [15:0]   alu_a;
  logic [15:0]   alu_b;
  logic [4:0]    alu_operation;
  logic          alu_cin;
  logic [15:0]   alu_result;
  logic          alu_cout;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  alu_word_sequencer #(.WORDS(WORDS)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op        (req_op),
    .req_a         (req_a),
    .req_b         (req_b),
    .req_ci        (req_ci),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_result    (rsp_result),
    .rsp_co        (rsp_co),
    .rsp_zero      (rsp_zero),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_operation (alu_operation),
    .alu_cin       (alu_cin),
    .alu_result    (alu_result),
    .alu_cout      (alu_cout)
  );

  // 16-bit ALU with active-low carry in/out; logic ops emit an arbitrary carry
  always_comb begin
    logic [16:0] s;
    s          = '0;
    alu_result = 16'hDEAD;
    alu_cout   = 1'b0;
    case (alu_operation)
      5'b01001: begin
        s          = {1'b0, alu_a} + {1'b0, alu_b} + {16'b0, ~alu_cin};
        alu_result = s[15:0];
        alu_cout   = ~s[16];
      end
      5'b00110: begin
        s          = {1'b0, alu_a} + {1'b0, ~alu_b} + {16'b0, ~alu_cin};
        alu_result = s[15:0];
        alu_cout   = ~s[16];
      end
      5'b11011: begin
        alu_result = alu_a & alu_b;
        alu_cout   = alu_a[0] ^ alu_b[15];
      end
      5'b10110: begin
        alu_result = alu_a ^ alu_b;
        alu_cout   = ~(alu_a[3] & alu_b[7]);
      end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns {carry/borrow, result}
  function automatic logic [W:0] ref_model(input logic [1:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic ci);
    case (op)
      2'b00:   return {1'b0, a} + {1'b0, b} + (W+1)'(ci);
      2'b01:   return {1'b0, a} - {1'b0, b} - (W+1)'(ci);
      2'b10:   return {1'b0, a & b};
      default: return {1'b0, a ^ b};
    endcase
  endfunction

  function automatic logic [4:0] op_code(input logic [1:0] op);
    case (op)
      2'b00:   return 5'b01001;
      2'b01:   return 5'b00110;
      2'b10:   return 5'b11011;
      default: return 5'b10110;
    endcase
  endfunction

  function automatic logic first_cin(input logic [1:0] op, input logic ci);
    case (op)
      2'b00:   return ~ci;
      2'b01:   return ci;
      default: return 1'b1;
    endcase
  endfunction

  task automatic wait_rsp(output int unsigned cyc);
    cyc = 0;
    while (!rsp_valid && cyc < 20) begin
      tick();
      cyc++;
    end
  endtask

  task automatic present(input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic ci);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_ci    = ci;
  endtask

  task automatic run_txn(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ci, input int unsigned stall);
    logic [W:0]  exp;
    int unsigned cyc;
    exp = ref_model(op, a, b, ci);
    check("idle_ready", W'(req_ready), W'(1'b1));
    present(op, a, b, ci);
    tick();
    req_valid = 1'b0;
    req_a     = {$urandom, $urandom};
    req_b     = {$urandom, $urandom};
    req_ci    = ~ci;
    check("exec_ready", W'(req_ready), W'(1'b0));
    check("slice0_opcode", W'(alu_operation), W'(op_code(op)));
    check("slice0_cin", W'(alu_cin), W'(first_cin(op, ci)));
    check("slice0_a", W'(alu_a), W'(a[15:0]));
    wait_rsp(cyc);
    check("latency", W'(cyc), W'(WORDS));
    check("result", rsp_result, exp[W-1:0]);
    check("carry_out", W'(rsp_co), W'(exp[W]));
    check("zero", W'(rsp_zero), W'(exp[W-1:0] == '0));
    check("done_alu_op", W'(alu_operation), '0);
    for (int unsigned i = 0; i < stall; i++) begin
      tick();
      check("hold_valid", W'(rsp_valid), W'(1'b1));
      check("hold_result", rsp_result, exp[W-1:0]);
      check("hold_ready", W'(req_ready), W'(1'b0));
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("rsp_drop", W'(rsp_valid), W'(1'b0));
    check("ready_back", W'(req_ready), W'(1'b1));
  endtask

  initial begin
    logic [W:0]    e1;
    logic [W:0]    e2;
    logic [W-1:0]  ra;
    logic [W-1:0]  rb;
    int unsigned   cyc;

    rst       = 1'b1;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_a     = '0;
    req_b     = '0;
    req_ci    = 1'b0;
    rsp_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_req_ready", W'(req_ready), W'(1'b1));
    check("rst_rsp_valid", W'(rsp_valid), W'(1'b0));
    check("rst_result", rsp_result, '0);
    check("rst_co", W'(rsp_co), W'(1'b0));
    check("rst_zero", W'(rsp_zero), W'(1'b1));
    check("rst_alu_op", W'(alu_operation), '0);
    check("rst_alu_cin", W'(alu_cin), W'(1'b1));
    check("rst_alu_a", W'(alu_a), '0);

    // Early rsp_ready must not matter
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("early_rsp_ready", W'(rsp_valid), W'(1'b0));

    run_txn(2'b00, 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 0);
    run_txn(2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1);
    run_txn(2'b01, 64'h0, 64'h1, 1'b0, 0);
    run_txn(2'b01, 64'h5, 64'h5, 1'b1, 0);
    run_txn(2'b01, 64'h5, 64'h3, 1'b0, 2);
    run_txn(2'b10, 64'hCAFE_BABE_DEAD_BEEF, 64'hFFFF_0000_FFFF_0000, 1'b1, 0);
    run_txn(2'b11, 64'hCAFE_BABE_DEAD_BEEF, 64'hFFFF_0000_FFFF_0000, 1'b1, 0);

    // Back-pressure with a second request waiting in DONE
    e1 = ref_model(2'b00, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1);
    e2 = ref_model(2'b01, 64'h1, 64'h2, 1'b0);
    present(2'b00, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1);
    tick();
    present(2'b01, 64'h1, 64'h2, 1'b0);
    wait_rsp(cyc);
    check("bp_latency", W'(cyc), W'(WORDS));
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      check("bp_valid", W'(rsp_valid), W'(1'b1));
      check("bp_result", rsp_result, e1[W-1:0]);
      check("bp_req_ready", W'(req_ready), W'(1'b0));
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("bp_ready_back", W'(req_ready), W'(1'b1));
    tick();
    req_valid = 1'b0;
    check("bp_second_accept", W'(req_ready), W'(1'b0));
    check("bp_second_op", W'(alu_operation), W'(5'b00110));
    wait_rsp(cyc);
    check("bp_second_latency", W'(cyc), W'(WORDS));
    check("bp_second_result", rsp_result, e2[W-1:0]);
    check("bp_second_co", W'(rsp_co), W'(e2[W]));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Abort mid-operation at slice 2
    present(2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    check("abort_slice2_a", W'(alu_a), W'(16'hFFFF));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_rsp_valid", W'(rsp_valid), W'(1'b0));
    check("abort_req_ready", W'(req_ready), W'(1'b1));
    check("abort_alu_op", W'(alu_operation), '0);
    check("abort_alu_cin", W'(alu_cin), W'(1'b1));
    check("abort_result", rsp_result, '0);
    check("abort_zero", W'(rsp_zero), W'(1'b1));
    for (int unsigned i = 0; i < WORDS + 2; i++) begin
      tick();
      check("abort_no_rsp", W'(rsp_valid), W'(1'b0));
    end

    for (int unsigned t = 0; t < 40; t++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: ra = '1;
        1: rb = ra;
        2: rb = W'($urandom_range(0, 3));
        default: ;
      endcase
      run_txn(2'($urandom_range(0, 3)), ra, rb, 1'($urandom_range(0, 1)),
              $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_word_sequencer.md
# alu_word_sequencer

Multi-word arithmetic/logic sequencer that drives one shared `top_alu_16` instance to execute operations on operands of `16*WORDS` bits. It slices each operand into 16-bit words, issues them to the ALU one per cycle from least-significant to most-significant word, and chains the ALU's active-low carry between slices. Sits between an instruction/requester front end (valid/ready) and the combinational 16-bit ALU.

## Interface
- `WORDS`, 4: number of 16-bit slices; legal range 2..8.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  sequencer accepts a request this cycle.
- `req_op`  in  2  00 ADD, 01 SUB, 10 AND, 11 XOR.
- `req_a`, `req_b`  in  16*WORDS  operands.
- `req_ci`  in  1  active-high carry-in (ADD) / borrow-in (SUB); ignored for logic ops.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer takes result.
- `rsp_result`  out  16*WORDS  result.
- `rsp_co`  out  1  active-high carry-out (ADD) / borrow-out (SUB); 0 for logic ops.
- `rsp_zero`  out  1  `rsp_result == 0`.
- `alu_a`, `alu_b`  out  16  current slice operands.
- `alu_operation`  out  5  {mode, sel[3:0]}: ADD 5'b01001, SUB 5'b00110, AND 5'b11011, XOR 5'b10110.
- `alu_cin`  out  1  active-low carry into ALU.
- `alu_result`  in  16  ALU slice result (combinational).
- `alu_cout`  in  1  active-low ALU carry-out.

## Operation
- States: IDLE, EXEC, DONE.
- IDLE: `req_ready`=1. On `req_valid & req_ready`: latch a, b, op, ci; slice index `idx`=0; → EXEC.
- EXEC: drive `alu_a = a[16*idx +: 16]`, `alu_b = b[16*idx +: 16]`, `alu_operation` per latched op.
  - `alu_cin` at idx=0: ADD → `~ci`; SUB → `ci` (pin 0 injects +1, i.e. no borrow); logic → 1.
  - `alu_cin` at idx>0: registered `alu_cout` from previous slice (pin-to-pin, no inversion).
  - Each cycle capture `alu_result` into result word `idx` and `alu_cout` into carry register; `idx`++.
  - At idx=WORDS-1 → DONE.
- DONE: `rsp_valid`=1, outputs stable. `rsp_co`: ADD → `~last alu_cout`; SUB → `last alu_cout`; logic → 0. On `rsp_ready` → IDLE.
- Outside EXEC: `alu_a`=`alu_b`=0, `alu_operation`=5'b0, `alu_cin`=1.
- Arithmetic is modulo 2^(16*WORDS); result words for logic ops are independent of carry.
- `req_ready` is 0 in EXEC and DONE; requests there are held off, not dropped.

## Timing
- Reset: state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_result`=0, `rsp_co`=0, `rsp_zero`=1, ALU outputs at idle values.
- Request accepted at edge 0; slices issued in cycles 1..WORDS; `rsp_valid` rises after edge WORDS (latency WORDS+1 cycles to first response cycle).
- ALU is combinational within a cycle; no ALU pipeline stage assumed.
- `rsp_valid` held with stable data until `rsp_ready`; earliest next accept is the cycle after the response handshake (`req_ready` returns in IDLE).
- `rsp_ready` asserted before `rsp_valid` has no effect.
- `rst` in EXEC or DONE aborts immediately: next cycle is IDLE with reset values; partial result discarded.
- `rsp_zero` computed from the registered result, valid whenever `rsp_valid`=1.

## Test plan
- ADD, WORDS=4: a=64'h0000_0000_FFFF_FFFF, b=1, ci=0 → result 64'h0000_0001_0000_0000, co=0, carry ripples across slices 0→2; `rsp_valid` on cycle 5.
- ADD overflow: a=64'hFFFF_FFFF_FFFF_FFFF, b=0, ci=1 → result 0, co=1, zero=1.
- SUB borrow: a=0, b=1, ci=0 → result 64'hFFFF_FFFF_FFFF_FFFF, co=1; a=5, b=5, ci=1 → result 64'hFFFF_FFFF_FFFF_FFFF, co=1; a=5, b=3, ci=0 → 2, co=0.
- Logic: AND a=64'hCAFE_BABE_DEAD_BEEF, b=64'hFFFF_0000_FFFF_0000, ci=1 → 64'hCAFE_0000_DEAD_0000, co=0; XOR same operands → 64'h3501_BABE_2152_BEEF.
- Handshake: hold `rsp_ready`=0 for 3 cycles in DONE → result stable, `req_ready`=0, second `req_valid` stalled, accepted the cycle after response handshake.
- Reset mid-EXEC at idx=2 → next cycle IDLE, `rsp_valid`=0, `alu_operation`=0, `alu_cin`=1, no response emitted.
